// File: rtl/fwft_pkt_framer_if.sv
// Framer-facing bundle: FWFT FIFO read port plus the outgoing valid/ready stream.
// master is the framer's view, slave the surrounding environment's view.
interface fwft_pkt_framer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_rdata_vld;
  logic             fifo_rden;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (
    input  fifo_rdata, fifo_rdata_vld, m_ready,
    output fifo_rden, m_data, m_valid, m_last
  );

  modport slave (
    output fifo_rdata, fifo_rdata_vld, m_ready,
    input  fifo_rden, m_data, m_valid, m_last
  );
endinterface

// File: rtl/fwft_pkt_framer.sv
// Pops words from an FWFT FIFO and frames them as header / 1..PKT_LEN payload /
// count trailer packets on a one-stage registered valid/ready stream.
module fwft_pkt_framer #(
  parameter int unsigned     WIDTH    = 8,
  parameter int unsigned     PKT_LEN  = 64,
  parameter int unsigned     TIMEOUT  = 256,
  parameter logic [WIDTH-1:0] HDR_WORD = WIDTH'(8'hA5)
) (
  input  logic                clk,
  input  logic                rst,
  fwft_pkt_framer_if.master   bus,
  output logic                flush_pulse,
  output logic [15:0]         pkt_cnt
);

  localparam int unsigned      TW      = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] PKT_MAX = WIDTH'(PKT_LEN);
  localparam logic [TW-1:0]    TMAX    = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, PAYLOAD, TRAILER} state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [TW-1:0]    tcnt;
  logic             slot_free;
  logic             pop;

  assign slot_free     = !bus.m_valid || bus.m_ready;
  // A pop is only granted when the word lands in the output register this cycle.
  assign pop           = (state == PAYLOAD) && bus.fifo_rdata_vld && slot_free && (cnt < PKT_MAX);
  assign bus.fifo_rden = pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      tcnt        <= '0;
      bus.m_data  <= '0;
      bus.m_valid <= 1'b0;
      bus.m_last  <= 1'b0;
      flush_pulse <= 1'b0;
      pkt_cnt     <= '0;
    end else begin
      flush_pulse <= 1'b0;
      // Drain the slot on a transfer; a load below in the same cycle overrides.
      if (bus.m_ready) begin
        bus.m_valid <= 1'b0;
        bus.m_last  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (bus.fifo_rdata_vld && slot_free) begin
            bus.m_data  <= HDR_WORD;
            bus.m_valid <= 1'b1;
            bus.m_last  <= 1'b0;
            cnt         <= '0;
            tcnt        <= '0;
            state       <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (pop) begin
            bus.m_data  <= bus.fifo_rdata;
            bus.m_valid <= 1'b1;
            bus.m_last  <= 1'b0;
            cnt         <= cnt + 1'b1;
            tcnt        <= '0;
            if ((cnt + 1'b1) == PKT_MAX) state <= TRAILER;
          end else if (!bus.fifo_rdata_vld) begin
            if (tcnt != TMAX) tcnt <= tcnt + 1'b1;
            if (tcnt == TMAX - 1'b1) begin
              state       <= TRAILER;
              flush_pulse <= 1'b1;
            end
          end
        end
        TRAILER: begin
          if (slot_free) begin
            bus.m_data  <= cnt;
            bus.m_valid <= 1'b1;
            bus.m_last  <= 1'b1;
            pkt_cnt     <= pkt_cnt + 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fwft_pkt_framer.sv
// Directed-sequence bench for fwft_pkt_framer with a queue-based FIFO model and
// a packetizing reference model (header, chunks of PKT_LEN, count trailer).
module tb_fwft_pkt_framer;
  localparam int unsigned W       = 8;
  localparam int unsigned PKT_LEN = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam logic [7:0]  HDR     = 8'hA5;
  localparam int          BUDGET  = 4000;

  logic        clk;
  logic        rst;
  logic        flush_pulse;
  logic [15:0] pkt_cnt;

  fwft_pkt_framer_if #(.WIDTH(W)) bus ();

  fwft_pkt_framer #(
    .WIDTH   (W),
    .PKT_LEN (PKT_LEN),
    .TIMEOUT (TIMEOUT),
    .HDR_WORD(HDR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flush_pulse(flush_pulse),
    .pkt_cnt    (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] fq[$];
  logic [7:0] batch[$];
  logic [8:0] exp_q[$];
  int         exp_pops = 0, exp_pkts = 0, exp_flush = 0;
  int         pops = 0, flushes = 0, beats = 0;
  int         cyc = 0, first_cyc = -1, last_cyc = -1;
  bit         rdy_rand = 1'b0;
  bit         stalled  = 1'b0;
  logic [8:0] held;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: every word in batch is available, so it splits into full
  // PKT_LEN packets plus one timed-out remainder.
  task automatic packetize();
    int n;
    while (batch.size() != 0) begin
      n = (batch.size() < PKT_LEN) ? batch.size() : PKT_LEN;
      exp_q.push_back({1'b0, HDR});
      repeat (n) exp_q.push_back({1'b0, batch.pop_front()});
      exp_q.push_back({1'b1, 8'(n)});
      if (n < PKT_LEN) exp_flush++;
      exp_pops += n;
      exp_pkts++;
    end
  endtask

  task automatic push_words(input int n, input bit rnd);
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin
      w = rnd ? 8'($urandom) : 8'(i);
      fq.push_back(w);
      batch.push_back(w);
    end
  endtask

  task automatic step();
    logic [8:0] e;
    bus.fifo_rdata_vld = (fq.size() != 0);
    bus.fifo_rdata     = (fq.size() != 0) ? fq[0] : '0;
    bus.m_ready        = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    if (!rst) begin
      check("reset_outs", {bus.m_valid, bus.m_last, bus.fifo_rden, flush_pulse, bus.m_data, pkt_cnt}, '0);
    end else begin
      if (stalled) begin
        check("stall_valid", bus.m_valid, 1);
        check("stall_hold", {bus.m_last, bus.m_data}, held);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) check("extra_beat", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("beat_data", bus.m_data, e[7:0]);
          check("beat_last", bus.m_last, e[8]);
        end
        beats++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (bus.fifo_rden) begin
        pops++;
        if (fq.size() != 0) void'(fq.pop_front());
      end
      if (flush_pulse) flushes++;
    end
    stalled = rst && bus.m_valid && !bus.m_ready;
    held    = {bus.m_last, bus.m_data};
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || fq.size() != 0) && k < BUDGET) begin
      step();
      k++;
    end
    check("drain_done", (k < BUDGET), 1);
    repeat (TIMEOUT + 4) step();
    check("pkt_cnt", pkt_cnt, 16'(exp_pkts));
    check("pops", pops, exp_pops);
    check("flushes", flushes, exp_flush);
  endtask

  initial begin
    int p0;
    rst = 1'b0;
    bus.m_ready = 1'b1;
    bus.fifo_rdata_vld = 1'b0;
    bus.fifo_rdata = '0;

    // Reset held with the FIFO already non-empty; then one full packet.
    push_words(4, 1'b0);
    repeat (10) step();
    packetize();
    rst = 1'b1;
    step();
    check("lat_hdr", {bus.m_valid, bus.m_data}, {1'b1, HDR});
    step();
    check("lat_pay", {bus.m_valid, bus.m_data}, {1'b1, 8'h00});
    drain();

    // Six words: one full packet, then a two-word packet closed by timeout.
    push_words(6, 1'b0);
    packetize();
    drain();

    // Random backpressure on eight random words.
    rdy_rand = 1'b1;
    p0 = pops;
    push_words(8, 1'b1);
    packetize();
    drain();
    check("bp_pops", pops - p0, 8);

    // Random-length bursts under random backpressure.
    for (int b = 0; b < 4; b++) begin
      push_words($urandom_range(1, 11), 1'b1);
      packetize();
      drain();
    end
    rdy_rand = 1'b0;

    // Reset after two payload pops; the two unpopped words form the next packet.
    p0 = pops;
    push_words(4, 1'b1);
    packetize();
    for (int k = 0; k < 20 && (pops - p0) < 2; k++) step();
    check("mid_pops", pops - p0, 2);
    rst = 1'b0;
    #1;
    check("mid_valid", bus.m_valid, 0);
    exp_q.delete();
    exp_pkts = 0;
    exp_pops = pops;
    stalled  = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    batch = fq;
    check("mid_left", fq.size(), 2);
    packetize();
    drain();

    // Sustained throughput: 1024 words, no bubbles beyond header/trailer.
    beats = 0;
    first_cyc = -1;
    push_words(1024, 1'b1);
    packetize();
    drain();
    check("tp_beats", beats, 1536);
    check("tp_span", last_cyc - first_cyc + 1, 1536);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fwft_pkt_framer.md
Name: fwft_pkt_framer

Overview:
- Consumer stage placed directly downstream of fwft_sc_fifo.
- Pops words from the FIFO's first-word-fall-through read port and frames them into packets on a valid/ready stream.
- Packet format: header word HDR_WORD, then 1..PKT_LEN payload words, then a trailer word carrying the payload count, with m_last set on the trailer.
- A partial packet is closed by timeout when the FIFO stays empty.

Parameters:
- WIDTH, 8: data width; matches the FIFO WIDTH.
- PKT_LEN, 64: maximum payload words per packet; legal range 1..2^WIDTH-1.
- TIMEOUT, 256: consecutive empty-FIFO cycles in PAYLOAD that close a partial packet; must be at least 1.
- HDR_WORD, 8'hA5: header word value; only the low WIDTH bits are used.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- fifo_rdata  input  WIDTH  FIFO head word.
- fifo_rdata_vld  input  1  FIFO head word valid (FIFO not empty).
- fifo_rden  output  1  pop/acknowledge of the head word; combinational.
- m_data  output  WIDTH  stream data, registered.
- m_valid  output  1  stream valid, registered.
- m_ready  input  1  downstream ready.
- m_last  output  1  marks the trailer word, registered.
- flush_pulse  output  1  one-cycle pulse when a timeout closes a packet.
- pkt_cnt  output  16  count of trailers loaded; wraps at 2^16.

Behaviour:
- Reset (rst low, asynchronous):
  - State is IDLE.
  - m_valid=0, m_last=0, m_data=0, flush_pulse=0, pkt_cnt=0.
  - Internal payload counter and timeout counter are 0.
  - fifo_rden=0 while in reset.
- Output register:
  - One stage. slot_free = !m_valid || m_ready.
  - While m_valid && !m_ready, m_data and m_last hold stable.
  - m_valid drops only after a transfer when nothing new is loaded.
- fifo_rden = (state==PAYLOAD) && fifo_rdata_vld && slot_free && (cnt < PKT_LEN).
  - A FIFO word is never popped unless it is loaded into the output register in the same cycle.
- State machine, IDLE / PAYLOAD / TRAILER:
  - IDLE: when fifo_rdata_vld && slot_free, load HDR_WORD (m_last=0), clear cnt and timeout counter, go to PAYLOAD. The FIFO word is not popped in this cycle.
  - PAYLOAD, on a pop: load fifo_rdata, cnt+1, clear the timeout counter. If the new cnt equals PKT_LEN, go to TRAILER.
  - PAYLOAD, when !fifo_rdata_vld: timeout counter +1, saturating. When it reaches TIMEOUT, go to TRAILER and assert flush_pulse for exactly that cycle.
  - PAYLOAD, when fifo_rdata_vld && !slot_free: the timeout counter holds.
  - TRAILER: when slot_free, load cnt (truncated to WIDTH) with m_last=1, pkt_cnt+1, go to IDLE.
- cnt is always at least 1 on entering TRAILER. The FIFO cannot withdraw its head word, so the first PAYLOAD cycle pops once the slot is free.
- Latency with m_ready=1 and an idle framer: head word valid at cycle t gives the header on m_valid at t+1 and the first payload word at t+2.
- Per-packet overhead: 2 cycles (header and trailer); no other bubbles under sustained input.
- Boundary conditions:
  - PKT_LEN=1: a header, one payload word, then trailer value 1.
  - When a packet reaches PKT_LEN, no further pop occurs until the next packet's header has been loaded.
  - Reset mid-packet discards the partial packet and any in-flight output word. Words already popped are lost; unpopped FIFO words remain for the next packet.
  - Simultaneous output transfer and load in the same cycle keeps m_valid=1 (back-to-back).

Test Plan:
- Configuration for all scenarios: WIDTH=8, PKT_LEN=4, TIMEOUT=8.
- Reset: hold rst low for 10 cycles with fifo_rdata_vld=1 -> m_valid=0, m_last=0, fifo_rden=0, pkt_cnt=0 throughout.
- Full packet: FIFO holds 00..03, m_ready=1 -> stream A5,00,01,02,03,04 with m_last only on 04; pkt_cnt=1; flush_pulse never asserted.
- Timeout flush: FIFO receives 00..05 then stays empty -> A5,00,01,02,03,04(last), then A5,04,05. After 8 empty cycles, flush_pulse pulses once and trailer 02(last) follows; pkt_cnt=2.
- Backpressure: 8 words with m_ready random at 50% -> identical word sequence to the m_ready=1 case. m_data/m_last are stable while stalled; pops equal payload words delivered (8).
- Reset mid-packet: reset after 2 payload words, with 2 words still in the FIFO -> m_valid=0 immediately. After release the next packet starts with A5 and carries the 2 remaining words, with trailer 02 after timeout.
- Throughput: 1024 words written continuously, m_ready=1 -> 256 packets, pkt_cnt=256, all trailers 04, exactly 1536 valid output beats, sequence data intact.
